out_arbiter: RTL and testbench

OUT_ARBITER -- requirements
Module: out_arbiter

---
 rtl/out_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_out_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : out_arbiter
// Description : Output-port arbiter for a wormhole router. Chooses one of
//               N_IN input FIFOs by round-robin on packet HEAD flits and keeps
//               that input locked until its TAIL flit leaves. Flits go out
//               through a single registered stage with valid/ready handshake.
//               Optional build macro OUT_ARB_FLIT_CNT_EN adds a 32-bit
//               transferred-flit counter on port flit_count.
// Revision    : 1.0 - initial release
// ============================================================================
module out_arbiter #(
   parameter  int N_IN       = 5,
   parameter  int DATA_WIDTH = 32,
   localparam int IDX_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_IN-1:0]            fifo_empty,
   input  logic [N_IN*DATA_WIDTH-1:0] fifo_dout,
   output logic [N_IN-1:0]            fifo_pop,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_data,
   input  logic                       out_ready,
   output logic                       busy,
   output logic [IDX_W-1:0]           owner
`ifdef OUT_ARB_FLIT_CNT_EN
   ,
   output logic [31:0]                flit_count
`endif
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;

   logic [N_IN-1:0]         elig;
   logic [IDX_W-1:0]        win;
   logic                    win_found;
   logic [IDX_W-1:0]        sel;
   logic [DATA_WIDTH-1:0]   sel_flit;
   logic                    sel_empty;
   logic                    sel_tail;
   logic                    load;
   logic                    do_pop;

   assign load = !out_valid_q || out_ready;

   // Eligibility: a non-empty input presenting a HEAD flit may start a packet.
   always_comb begin
      elig = '0;
      for (int j = 0; j < N_IN; j++) begin
         elig[j] = !fifo_empty[j] && fifo_dout[j*DATA_WIDTH + DATA_WIDTH - 1];
      end
   end

   // Round-robin search starting just after the last packet's input.
   always_comb begin
      int cand;
      win       = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int k = 1; k <= N_IN; k++) begin
         cand = (int'(rr_ptr_q) + k) % N_IN;
         for (int j = 0; j < N_IN; j++) begin
            if (!win_found && (cand == j) && elig[j]) begin
               win_found = 1'b1;
               win       = IDX_W'(j);
            end
         end
      end
   end

   // Source select: round-robin winner while idle, locked owner otherwise.
   assign sel = (state_q == S_IDLE) ? win : owner_q;

   // Mux the selected input's head flit and empty flag.
   always_comb begin
      sel_flit  = '0;
      sel_empty = 1'b1;
      for (int j = 0; j < N_IN; j++) begin
         if (sel == IDX_W'(j)) begin
            sel_flit  = fifo_dout[j*DATA_WIDTH +: DATA_WIDTH];
            sel_empty = fifo_empty[j];
         end
      end
   end

   assign sel_tail = sel_flit[DATA_WIDTH-2];

   // Next-state, pop decision and round-robin pointer update.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      do_pop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found && load) begin
               do_pop  = 1'b1;
               owner_d = win;
               if (sel_tail) begin
                  rr_ptr_d = win;
               end else begin
                  state_d = S_LOCKED;
               end
            end
         end
         S_LOCKED: begin
            if (!sel_empty && load) begin
               do_pop = 1'b1;
               if (sel_tail) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = owner_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A reset cycle must never consume a flit from any FIFO.
      if (reset) begin
         do_pop = 1'b0;
      end
   end

   // One-hot pop strobe toward the selected input.
   always_comb begin
      fifo_pop = '0;
      for (int j = 0; j < N_IN; j++) begin
         fifo_pop[j] = do_pop && (sel == IDX_W'(j));
      end
   end

   // State, pointer and output register; output loads only when free or drained.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= IDX_W'(N_IN - 1);
         owner_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         if (load) begin
            out_valid_q <= do_pop;
            if (do_pop) begin
               out_data_q <= sel_flit;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == S_LOCKED);
   assign owner     = owner_q;

`ifdef OUT_ARB_FLIT_CNT_EN
   logic [31:0] flit_count_q;

   // Count every accepted output transfer; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         flit_count_q <= '0;
      end else if (out_valid_q && out_ready) begin
         flit_count_q <= flit_count_q + 32'd1;
      end
   end

   assign flit_count = flit_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_arbiter
// Description : Randomized self-checking bench for out_arbiter. The bench
//               owns the input FIFOs as queues, a packet-level reference model
//               predicts every pop, and a scoreboard checks output flits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_arbiter;

   localparam int N  = 5;
   localparam int DW = 32;

   typedef logic [DW-1:0] flit_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    fifo_empty;
   logic [N*DW-1:0] fifo_dout;
   logic [N-1:0]    fifo_pop;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_ready;
   logic            busy;
   logic [2:0]      owner;
`ifdef OUT_ARB_FLIT_CNT_EN
   logic [31:0]     flit_count;
`endif

   always #5 clk = ~clk;

   out_arbiter #(.N_IN(N), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_pop   (fifo_pop),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .owner      (owner)
`ifdef OUT_ARB_FLIT_CNT_EN
      ,
      .flit_count (flit_count)
`endif
   );

   // Bench-owned FIFO contents, pending packet sources and expected outputs.
   flit_t fq[N][$];
   flit_t src[N][$];
   flit_t sb[$];

   int errors = 0;
   int checks = 0;
   int pending = -1;
   bit gen_en = 1'b0;
   int ready_pct = 100;
   int exp_cnt = 0;

   // Reference model state: packet lock, round-robin pointer, output slot.
   bit lock = 1'b0;
   int lock_in = 0;
   int rr = N - 1;
   int cur_owner = 0;
   bit exp_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifos();
      for (int i = 0; i < N; i++) begin
         fifo_empty[i] = (fq[i].size() == 0);
         fifo_dout[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
      end
   endtask

   task automatic gen_packet(input int i);
      int len;
      flit_t f;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
         f = flit_t'($urandom);
         f[DW-1] = (j == 0);
         f[DW-2] = (j == len - 1);
         src[i].push_back(f);
      end
   endtask

   // One clock of stimulus: retire last predicted pop, then new arrivals.
   task automatic step(input bit do_reset);
      @(posedge clk);
      #1;
      if (pending >= 0) begin
         void'(fq[pending].pop_front());
         pending = -1;
      end
      reset = do_reset;
      if (do_reset) begin
         for (int i = 0; i < N; i++) begin
            fq[i].delete();
            src[i].delete();
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (gen_en && src[i].size() == 0 && fq[i].size() < 6 && $urandom_range(0, 99) < 25)
               gen_packet(i);
            if (src[i].size() != 0 && $urandom_range(0, 99) < 70)
               fq[i].push_back(src[i].pop_front());
         end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      drive_fifos();
   endtask

   // Reference model: decides the expected pop from packet-level rules.
   always @(negedge clk) begin
      bit    load;
      int    pick;
      int    c;
      flit_t f;
      if (reset) begin
         check("pop_in_reset", 64'(fifo_pop), 64'd0);
         lock      = 1'b0;
         lock_in   = 0;
         rr        = N - 1;
         cur_owner = 0;
         exp_valid = 1'b0;
         sb.delete();
         pending   = -1;
      end else begin
         check("out_valid", 64'(out_valid), 64'(exp_valid));
         check("busy", 64'(busy), 64'(lock));
         check("owner", 64'(owner), 64'(cur_owner));
         load = !exp_valid || out_ready;
         pick = -1;
         if (load) begin
            if (lock) begin
               if (fq[lock_in].size() != 0) pick = lock_in;
            end else begin
               for (int k = 1; k <= N; k++) begin
                  c = (rr + k) % N;
                  if (pick < 0 && fq[c].size() != 0 && fq[c][0][DW-1]) pick = c;
               end
            end
         end
         check("fifo_pop", 64'(fifo_pop), (pick >= 0) ? (64'd1 << pick) : 64'd0);
         if (pick >= 0) begin
            f = fq[pick][0];
            sb.push_back(f);
            if (!lock) cur_owner = pick;
            if (f[DW-2]) begin
               lock = 1'b0;
               rr   = pick;
            end else begin
               lock    = 1'b1;
               lock_in = pick;
            end
         end
         if (load) exp_valid = (pick >= 0);
         pending = pick;
      end
   end

   // Monitor: compares each accepted output flit with the scoreboard head.
   always @(negedge clk) begin
      flit_t e;
      if (reset) begin
         exp_cnt = 0;
      end else if (out_valid && out_ready) begin
         exp_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_data: got %0h expected no flit at %0t", out_data, $time);
         end else begin
            e = sb.pop_front();
            check("out_data", 64'(out_data), 64'(e));
         end
      end
   end

   initial begin
      bit drained;
      reset      = 1'b1;
      out_ready  = 1'b0;
      fifo_empty = '1;
      fifo_dout  = '0;
      repeat (3) step(1'b1);
      step(1'b0);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_owner", 64'(owner), 64'd0);

      // Idle with all FIFOs empty.
      gen_en = 1'b0;
      repeat (5) step(1'b0);

      // Random traffic, full downstream rate then back-pressure.
      gen_en = 1'b1;
      ready_pct = 100;
      repeat (400) step(1'b0);
      ready_pct = 60;
      repeat (600) step(1'b0);

      // Reset in the middle of traffic aborts any lock.
      repeat (2) step(1'b1);
      ready_pct = 80;
      repeat (400) step(1'b0);

      // Drain everything outstanding within a bounded budget.
      gen_en = 1'b0;
      ready_pct = 70;
      drained = 1'b0;
      for (int t = 0; t < 2000 && !drained; t++) begin
         step(1'b0);
         drained = (sb.size() == 0) && !lock;
         for (int i = 0; i < N; i++)
            if (fq[i].size() != 0 || src[i].size() != 0) drained = 1'b0;
      end
      check("drain_done", 64'(drained), 64'd1);
`ifdef OUT_ARB_FLIT_CNT_EN
      @(negedge clk);
      check("flit_count", 64'(flit_count), 64'(exp_cnt));
      step(1'b1);
      step(1'b0);
      @(negedge clk);
      check("flit_count_rst", 64'(flit_count), 64'd0);
`endif

      // A stray body flit at an idle head must never be popped.
      step(1'b1);
      step(1'b0);
      @(posedge clk);
      #1;
      fq[4].push_back(flit_t'(32'h0000_00A5));
      drive_fifos();
      ready_pct = 100;
      repeat (5) step(1'b0);
      step(1'b1);
      step(1'b0);
      step(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
